// File: rtl/keyev_pkg.sv
// Shared definitions for the key event queue: key indices, event record
// layout and the fixed-priority pick helper used by the arbiter.
package keyev_pkg;

  localparam int NUM_KEYS = 5;
  localparam int EVT_W    = 20;

  localparam logic [2:0] KEY_A     = 3'd0;
  localparam logic [2:0] KEY_S     = 3'd1;
  localparam logic [2:0] KEY_K     = 3'd2;
  localparam logic [2:0] KEY_L     = 3'd3;
  localparam logic [2:0] KEY_ENTER = 3'd4;

  // Event record as stored in the FIFO: {key, press, stamp}.
  typedef struct packed {
    logic [2:0]  key;
    logic        press;
    logic [15:0] stamp;
  } key_evt_t;

  // Index of the lowest set bit (0 when none is set; callers check |v first).
  function automatic logic [2:0] first_set(input logic [NUM_KEYS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise the caller drops it.
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == (AW + 1)'(DEPTH));
  assign do_pop_s  = rd_en & (count_r != '0);
  assign do_push_s = wr_en & (~full_s | do_pop_s);
  assign count     = count_r;

  // Storage array; cleared on reset so an empty queue shows a zero head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of queue, forced to zero while empty.
  always_comb begin
    rd_data = '0;
    if (count_r != '0) rd_data = mem_r[rd_ptr_r];
    else               rd_data = '0;
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns five key levels into timestamped press/release events and queues
// them for a consumer. Presses win over releases, lower key index first.
module key_event_queue
  import keyev_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        s,
  input  logic        k,
  input  logic        l,
  input  logic        enter,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_key,
  output logic        evt_press,
  output logic [15:0] evt_time,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [15:0] now_time
);

  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [31:0]         pre_r;
  logic [15:0]         now_r;
  logic                tick_s;
  logic [NUM_KEYS-1:0] keys_s;
  logic [NUM_KEYS-1:0] prev_r;
  logic [NUM_KEYS-1:0] press_pend_r;
  logic [NUM_KEYS-1:0] rel_pend_r;
  logic [NUM_KEYS-1:0] rise_s;
  logic [NUM_KEYS-1:0] fall_s;
  logic [NUM_KEYS-1:0] clr_press_s;
  logic [NUM_KEYS-1:0] clr_rel_s;
  logic                push_req_s;
  logic [2:0]          sel_key_s;
  logic                sel_press_s;
  logic [CW-1:0]       count_s;
  logic                full_s;
  logic                pop_s;
  logic                drop_s;
  key_evt_t            wr_evt_s;
  key_evt_t            head_s;
  logic                ovf_r;

  assign tick_s   = (pre_r == 32'(DIV - 1));
  assign now_time = now_r;

  // Prescaler and 16-bit tick counter; the counter wraps on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= 32'd0;
      now_r <= 16'd0;
    end else if (tick_s) begin
      pre_r <= 32'd0;
      now_r <= now_r + 16'd1;
    end else begin
      pre_r <= pre_r + 32'd1;
    end
  end

  assign keys_s = {enter, l, k, s, a};
  assign rise_s = keys_s & ~prev_r;
  assign fall_s = ~keys_s & prev_r;

  // Pick one pending event: any press before any release, lowest key first.
  always_comb begin
    push_req_s  = 1'b0;
    sel_key_s   = 3'd0;
    sel_press_s = 1'b0;
    clr_press_s = '0;
    clr_rel_s   = '0;
    if (|press_pend_r) begin
      push_req_s  = 1'b1;
      sel_key_s   = first_set(press_pend_r);
      sel_press_s = 1'b1;
      clr_press_s = 5'b00001 << first_set(press_pend_r);
    end else if (|rel_pend_r) begin
      push_req_s  = 1'b1;
      sel_key_s   = first_set(rel_pend_r);
      sel_press_s = 1'b0;
      clr_rel_s   = 5'b00001 << first_set(rel_pend_r);
    end else begin
      push_req_s  = 1'b0;
    end
  end

  // Edge detector; a fresh edge re-sets a bit cleared by this cycle's push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r       <= '0;
      press_pend_r <= '0;
      rel_pend_r   <= '0;
    end else begin
      prev_r       <= keys_s;
      press_pend_r <= (press_pend_r & ~clr_press_s) | rise_s;
      rel_pend_r   <= (rel_pend_r & ~clr_rel_s) | fall_s;
    end
  end

  assign full_s   = (count_s == CW'(DEPTH));
  assign pop_s    = evt_valid & evt_ready;
  assign drop_s   = push_req_s & full_s & ~pop_s;
  assign wr_evt_s = '{key: sel_key_s, press: sel_press_s, stamp: now_r};

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_req_s),
    .wr_data (wr_evt_s),
    .rd_en   (evt_ready),
    .rd_data (head_s),
    .count   (count_s)
  );

  assign evt_valid = (count_s != '0);
  assign evt_key   = head_s.key;
  assign evt_press = head_s.press;
  assign evt_time  = head_s.stamp;
  assign overflow  = ovf_r;

  // Sticky drop flag; a drop on the clearing edge keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf_r <= 1'b0;
    else if (drop_s)  ovf_r <= 1'b1;
    else if (clr_ovf) ovf_r <= 1'b0;
    else              ovf_r <= ovf_r;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: main instance with 4 clocks per tick,
// second instance with 1 clock per tick for the timestamp wrap.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst, a, s, k, l, enter, evt_ready, clr_ovf;
  logic        evt_valid, evt_press, overflow;
  logic [2:0]  evt_key;
  logic [15:0] evt_time, now_time;

  logic        rst_b, kb_a, ready_b;
  logic        valid_b, press_b, ovf_b;
  logic [2:0]  key_b;
  logic [15:0] time_b, now_b;

  int cyc, cyc_b, total, bad;
  int exp_key[8]   = '{1, 2, 3, 4, 0, 1, 2, 4};
  int exp_press[8] = '{1, 1, 1, 1, 0, 0, 0, 0};

  key_event_queue #(.CLK_HZ(400), .TICK_HZ(100), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .s(s), .k(k), .l(l), .enter(enter),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .evt_time(evt_time), .overflow(overflow),
    .clr_ovf(clr_ovf), .now_time(now_time)
  );

  key_event_queue #(.CLK_HZ(1000), .TICK_HZ(1000), .DEPTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .a(kb_a), .s(1'b0), .k(1'b0), .l(1'b0), .enter(1'b0),
    .evt_valid(valid_b), .evt_ready(ready_b), .evt_key(key_b),
    .evt_press(press_b), .evt_time(time_b), .overflow(ovf_b),
    .clr_ovf(1'b0), .now_time(now_b)
  );

  always #5 clk = ~clk;

  // Rising edges since each reset release: the bench's time model.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) cyc_b <= 0;
    else        cyc_b <= cyc_b + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; rst_b = 1'b0;
    {a, s, k, l, enter} = 5'b0;
    evt_ready = 1'b0; clr_ovf = 1'b0;
    kb_a = 1'b0; ready_b = 1'b0;
    step(2);
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_key", 32'(evt_key), 0);
    check_eq("rst_press", 32'(evt_press), 0);
    check_eq("rst_time", 32'(evt_time), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_now", 32'(now_time), 0);
    rst = 1'b1; rst_b = 1'b1;

    // Tick counter steps once every 4 clocks.
    for (int i = 0; i < 9; i++) begin
      step(1);
      check_eq("tick", 32'(now_time), 32'(cyc / 4));
    end

    // Single press of s: two-edge latency and timestamp.
    s = 1'b1;
    step(1);
    check_eq("lat_early", 32'(evt_valid), 0);
    step(1);
    check_eq("lat_valid", 32'(evt_valid), 1);
    check_eq("s_key", 32'(evt_key), 1);
    check_eq("s_press", 32'(evt_press), 1);
    check_eq("s_time", 32'(evt_time), 32'((cyc - 1) / 4));
    evt_ready = 1'b1;
    s = 1'b0;
    step(4);
    check_eq("s_drained", 32'(evt_valid), 0);

    // Three simultaneous presses stream out in key order.
    a = 1'b1; k = 1'b1; enter = 1'b1;
    step(2);
    check_eq("m0_key", 32'(evt_key), 0);
    check_eq("m0_time", 32'(evt_time), 32'((cyc - 1) / 4));
    step(1);
    check_eq("m1_key", 32'(evt_key), 2);
    check_eq("m1_press", 32'(evt_press), 1);
    step(1);
    check_eq("m2_key", 32'(evt_key), 4);
    check_eq("m2_valid", 32'(evt_valid), 1);
    step(1);
    check_eq("m_empty", 32'(evt_valid), 0);
    a = 1'b0; k = 1'b0; enter = 1'b0;
    step(6);
    check_eq("m_rel_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;

    // Fill with 8 events, drop the ninth.
    {a, s, k, l, enter} = 5'b11111;
    step(7);
    check_eq("fill_ovf0", 32'(overflow), 0);
    check_eq("fill_key", 32'(evt_key), 0);
    a = 1'b0; s = 1'b0; k = 1'b0; l = 1'b0;
    step(6);
    check_eq("full_ovf", 32'(overflow), 1);
    check_eq("hold_key", 32'(evt_key), 0);
    check_eq("hold_press", 32'(evt_press), 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_eq("clr_ovf", 32'(overflow), 0);

    // Push into a full FIFO with a pop on the same edge.
    enter = 1'b0;
    step(1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(1);
    check_eq("pp_ovf", 32'(overflow), 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_valid", 32'(evt_valid), 1);
      check_eq("drain_key", 32'(evt_key), 32'(exp_key[i]));
      check_eq("drain_press", 32'(evt_press), 32'(exp_press[i]));
      step(1);
    end
    check_eq("drain_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;

    // l held through reset release yields one press at time 0.
    rst = 1'b0; l = 1'b1;
    step(1);
    check_eq("l_rst_valid", 32'(evt_valid), 0);
    rst = 1'b1;
    step(2);
    check_eq("l_key", 32'(evt_key), 3);
    check_eq("l_press", 32'(evt_press), 1);
    check_eq("l_time", 32'(evt_time), 0);
    a = 1'b1; s = 1'b1;
    step(3);
    check_eq("q3_valid", 32'(evt_valid), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_valid", 32'(evt_valid), 0);
    check_eq("async_key", 32'(evt_key), 0);
    check_eq("async_now", 32'(now_time), 0);
    step(1);
    rst = 1'b1;
    step(2);
    check_eq("rerst_key", 32'(evt_key), 0);
    check_eq("rerst_press", 32'(evt_press), 1);
    {a, s, k, l, enter} = 5'b0;

    // Second instance: one tick per clock, push lands just after the wrap.
    while (cyc_b != 65535) @(negedge clk);
    check_eq("wrap_pre", 32'(now_b), 65535);
    kb_a = 1'b1;
    step(1);
    check_eq("wrap_now", 32'(now_b), 0);
    check_eq("wrap_early", 32'(valid_b), 0);
    step(1);
    check_eq("wrap_valid", 32'(valid_b), 1);
    check_eq("wrap_time", 32'(time_b), 0);
    check_eq("wrap_key", 32'(key_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, timestamp tick rate in Hz (1 ms).
REQ-003 SHALL have parameter DEPTH, default 8, event FIFO depth; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock; the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports a, s, k, l, enter  input  1 each  key level from the PS/2 decoder: 1 = held, 0 = released; already synchronous to clk.
REQ-007 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-009 SHALL have port evt_key  output  3  key index: 0=a, 1=s, 2=k, 3=l, 4=enter.
REQ-010 SHALL have port evt_press  output  1  1 = press event, 0 = release event.
REQ-011 SHALL have port evt_time  output  16  tick count at which the event was pushed.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one event was dropped.
REQ-013 SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-014 SHALL have port now_time  output  16  current tick counter value, for the consumer's note scheduler.

Function
REQ-015 Tick counter SHALL increment now_time by 1 each CLK_HZ/TICK_HZ clk cycles and wrap from 65535 to 0.
REQ-016 Edge detector SHALL register the previous level of each key; a 0->1 change sets that key's pending-press bit and a 1->0 change sets its pending-release bit, both on the same edge that updates the previous level.
REQ-017 Arbiter SHALL push at most one event per cycle, chosen in this order: all pending presses first, lowest key index first; then pending releases, lowest key index first.
REQ-018 A pushed event's pending bit SHALL clear on the push edge; a new edge on the same key in that cycle SHALL re-set the bit and not be lost.
REQ-019 evt_time SHALL be the now_time value at the push edge.
REQ-020 FIFO SHALL be first-word-fall-through: evt_valid = (count != 0); evt_key, evt_press and evt_time show the head.
REQ-021 Pop SHALL occur on an edge where evt_valid & evt_ready; evt_* outputs SHALL hold stable while evt_valid & !evt_ready.
REQ-022 Latency: with an empty FIFO and no other pending events, evt_valid SHALL rise after the 2nd rising clk edge following an input change.
REQ-023 Full FIFO with a pending event and no pop in that cycle: the event SHALL be dropped, its pending bit cleared, and overflow set.
REQ-024 Full FIFO with a pop in the same cycle: the push SHALL be accepted and count SHALL stay at DEPTH.
REQ-025 Push and pop on a non-empty, non-full FIFO SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 overflow SHALL stay set until clr_ovf is high at an edge; when clr_ovf and a drop occur on the same edge, overflow SHALL end at 1.

Reset
REQ-027 While rst is low, all state SHALL be 0: tick counter, now_time, prescaler, previous levels, pending bits, FIFO pointers and count, and overflow. evt_valid SHALL be 0 and evt_key, evt_press and evt_time SHALL be 0.
REQ-028 A key held while rst deasserts SHALL produce one press event, because the previous level resets to 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and pending events immediately, without waiting for a clk edge.

Structure
REQ-030 Shared package keyev_pkg SHALL hold the key index constants (KEY_A .. KEY_ENTER), NUM_KEYS=5, and the event record layout (key 3 bits, press 1 bit, time 16 bits, 20 bits total).
REQ-031 The FIFO SHALL be one sub-module, key_evt_fifo (parameterised by DEPTH and width, FWFT, count output). Edge detection, arbitration and the tick counter SHALL stay in the top module.

Verification
REQ-032 Test: after reset, press s at t0 -> evt_valid rises after 2 edges; head is key=1, press=1, evt_time=now_time at the push edge.
REQ-033 Test: a, k and enter rise on the same cycle, evt_ready held high -> three events in order key 0, 2, 4, all press=1, on consecutive cycles.
REQ-034 Test: DEPTH=8, evt_ready=0, nine distinct edges -> count=8, overflow=1, the ninth event is absent; clr_ovf pulse -> overflow=0.
REQ-035 Test: full FIFO, evt_ready=1 on the same cycle a new edge is pushed -> count stays 8 and no overflow.
REQ-036 Test: CLK_HZ=TICK_HZ*4 -> now_time steps every 4 cycles and wraps 65535 -> 0; an event pushed across the wrap carries evt_time=0.
REQ-037 Test: l held through rst deassertion, then rst pulsed low with 3 events queued -> one l press event after the first release; the pulse empties the queue and evt_valid=0 immediately.
